// File: rtl/board_ctl.sv
// board_ctl: owner of one player's 16x16 cell store. Two requesters (local
// FSM on port 0, remote link on port 1) are arbitrated round-robin; each
// accepted op runs IDLE -> READ -> UPDATE, so a response appears three cycles
// after accept. Shots are read-modify-write. A separate read-only port feeds
// the grid renderer with one cycle of latency.
module board_ctl #(
  parameter int GRID_SIZE = 16,
  parameter int CELL_W    = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  output logic                              busy,
  input  logic                              req0_valid,
  output logic                              req0_ready,
  input  logic [1:0]                        req0_op,
  input  logic [$clog2(GRID_SIZE)-1:0]      req0_x,
  input  logic [$clog2(GRID_SIZE)-1:0]      req0_y,
  input  logic [CELL_W-1:0]                 req0_wdata,
  input  logic                              req1_valid,
  output logic                              req1_ready,
  input  logic [1:0]                        req1_op,
  input  logic [$clog2(GRID_SIZE)-1:0]      req1_x,
  input  logic [$clog2(GRID_SIZE)-1:0]      req1_y,
  input  logic [CELL_W-1:0]                 req1_wdata,
  output logic                              rsp_valid,
  output logic                              rsp_id,
  output logic [CELL_W-1:0]                 rsp_data,
  output logic                              rsp_hit,
  output logic [2*$clog2(GRID_SIZE):0]      ships_left,
  output logic                              all_sunk,
  input  logic [$clog2(GRID_SIZE)-1:0]      disp_x,
  input  logic [$clog2(GRID_SIZE)-1:0]      disp_y,
  output logic [CELL_W-1:0]                 disp_cell
);

  localparam int COORD_W = $clog2(GRID_SIZE);
  localparam int ADDR_W  = 2 * COORD_W;
  localparam int DEPTH   = GRID_SIZE * GRID_SIZE;
  localparam int SHIPS_W = ADDR_W + 1;

  localparam logic [CELL_W-1:0] CELL_EMPTY = CELL_W'(0);
  localparam logic [CELL_W-1:0] CELL_SHIP  = CELL_W'(1);
  localparam logic [CELL_W-1:0] CELL_MISS  = CELL_W'(2);
  localparam logic [CELL_W-1:0] CELL_HIT   = CELL_W'(3);

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SHOT  = 2'b10;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_READ   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   sweep_q;
  logic                last_id_q;
  logic                id_q;
  logic [1:0]          op_q;
  logic [COORD_W-1:0]  x_q;
  logic [COORD_W-1:0]  y_q;
  logic [CELL_W-1:0]   wdata_q;
  logic                rsp_valid_q;
  logic                rsp_id_q;
  logic [CELL_W-1:0]   rsp_data_q;
  logic                rsp_hit_q;
  logic [SHIPS_W-1:0]  ships_q;
  logic                placed_q;

  logic [CELL_W-1:0]   mem [DEPTH];
  logic [CELL_W-1:0]   ram_rd_q;
  logic [CELL_W-1:0]   disp_rd_q;
  logic                disp_zero_q;

  logic                accept_ok;
  logic                grant0;
  logic                grant1;
  logic                take0;
  logic                take1;

  logic                upd_we;
  logic [CELL_W-1:0]   upd_val;
  logic                upd_hit;
  logic                ships_inc;
  logic                ships_dec;

  logic                a_we;
  logic [ADDR_W-1:0]   a_addr;
  logic [CELL_W-1:0]   a_wdata;

  // Round-robin: a lone requester always wins; on contention the one not
  // served last wins. Nothing is accepted during rst or a clear request.
  assign accept_ok  = (state_q == ST_IDLE) && !clear && !rst;
  assign grant0     = req0_valid && (!req1_valid || last_id_q);
  assign grant1     = req1_valid && (!req0_valid || !last_id_q);
  assign take0      = accept_ok && grant0;
  assign take1      = accept_ok && grant1;
  assign req0_ready = take0;
  assign req1_ready = take1;

  // Decide the write-back and hit flag from the old cell value in UPDATE.
  always_comb begin
    upd_we  = 1'b0;
    upd_val = wdata_q;
    upd_hit = 1'b0;
    case (op_q)
      OP_WRITE: upd_we = 1'b1;
      OP_SHOT: begin
        if (ram_rd_q == CELL_SHIP) begin
          upd_we  = 1'b1;
          upd_val = CELL_HIT;
          upd_hit = 1'b1;
        end else if (ram_rd_q == CELL_EMPTY) begin
          upd_we  = 1'b1;
          upd_val = CELL_MISS;
        end
      end
      default: upd_we = 1'b0;
    endcase
  end

  assign ships_inc = (op_q == OP_WRITE) && (wdata_q == CELL_SHIP) && (ram_rd_q != CELL_SHIP);
  assign ships_dec = ((op_q == OP_WRITE) && (wdata_q != CELL_SHIP) && (ram_rd_q == CELL_SHIP))
                   || upd_hit;

  // Port A owner: the clear sweep in CLEAR, the latched cell otherwise.
  always_comb begin
    a_we    = 1'b0;
    a_addr  = {y_q, x_q};
    a_wdata = upd_val;
    if (state_q == ST_CLEAR) begin
      a_we    = 1'b1;
      a_addr  = sweep_q;
      a_wdata = CELL_EMPTY;
    end else if (state_q == ST_UPDATE) begin
      a_we = upd_we;
    end
  end

  // Dual-port cell store; both reads registered and read-before-write.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_wdata;
    end
    ram_rd_q  <= mem[a_addr];
    disp_rd_q <= mem[{disp_y, disp_x}];
  end

  // Blank the display output for reads issued while the board is clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_zero_q <= 1'b1;
    end else begin
      disp_zero_q <= (state_q == ST_CLEAR);
    end
  end

  // Controller sequencer: clear sweep, arbitration accept, read, update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      sweep_q     <= '0;
      last_id_q   <= 1'b1;
      id_q        <= 1'b0;
      op_q        <= 2'b00;
      x_q         <= '0;
      y_q         <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      ships_q     <= '0;
      placed_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          sweep_q <= sweep_q + ADDR_W'(1);
          if (sweep_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (clear) begin
            state_q  <= ST_CLEAR;
            sweep_q  <= '0;
            ships_q  <= '0;
            placed_q <= 1'b0;
          end else if (take0 || take1) begin
            id_q      <= take1;
            last_id_q <= take1;
            op_q      <= take1 ? req1_op    : req0_op;
            x_q       <= take1 ? req1_x     : req0_x;
            y_q       <= take1 ? req1_y     : req0_y;
            wdata_q   <= take1 ? req1_wdata : req0_wdata;
            state_q   <= ST_READ;
          end
        end
        ST_READ: begin
          state_q <= ST_UPDATE;
        end
        ST_UPDATE: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          rsp_data_q  <= ram_rd_q;
          rsp_hit_q   <= upd_hit;
          if (ships_inc) begin
            ships_q <= ships_q + SHIPS_W'(1);
          end else if (ships_dec) begin
            ships_q <= ships_q - SHIPS_W'(1);
          end
          if ((op_q == OP_WRITE) && (wdata_q == CELL_SHIP)) begin
            placed_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign busy       = (state_q == ST_CLEAR);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_hit    = rsp_hit_q;
  assign ships_left = ships_q;
  assign all_sunk   = placed_q && (ships_q == '0);
  assign disp_cell  = disp_zero_q ? CELL_EMPTY : disp_rd_q;

endmodule

// File: tb/tb_board_ctl.sv
// tb_board_ctl: cycle-stepped bench for board_ctl. A directed opening (ship
// placement, shots, contention) is followed by randomized traffic from both
// requesters, random clears and one reset during an in-flight operation.
// Expectations come from a board array plus a little handshake timing model.
module tb_board_ctl;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] wd;
  } req_t;

  localparam int N_CYCLES  = 3200;
  localparam int RND_START = 400;

  logic       clk = 1'b0;
  logic       rst, clear, busy;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_op, req1_op, req0_wdata, req1_wdata;
  logic [3:0] req0_x, req0_y, req1_x, req1_y;
  logic       rsp_valid, rsp_id, rsp_hit, all_sunk;
  logic [1:0] rsp_data, disp_cell;
  logic [8:0] ships_left;
  logic [3:0] disp_x, disp_y;

  always #5 clk = ~clk;

  board_ctl dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .ships_left(ships_left), .all_sunk(all_sunk),
    .disp_x(disp_x), .disp_y(disp_y), .disp_cell(disp_cell)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference state
  logic [1:0] board [256];   // logical board, updated when an op is accepted
  logic [1:0] shown [256];   // what the display port can see (after write-back)
  int   busy_left, infl, resp_due, cyc;
  bit   last_id, placed;
  bit   e_id, e_hit; logic [1:0] e_data, e_new, e_op; logic [7:0] e_addr;
  bit   l_id, l_hit; logic [1:0] l_data;
  logic [1:0] exp_disp;

  // Requester state
  req_t cur [2];
  bit   rv [2];
  req_t dq0 [$];
  req_t dq1 [$];
  int   rst_left;
  bit   abort_done;

  function automatic int count_ships();
    int n = 0;
    for (int i = 0; i < 256; i++) if (board[i] == 2'd1) n++;
    return n;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int k = $urandom_range(0, 9);
    r.op = (k < 4) ? 2'd1 : (k < 7) ? 2'd2 : (k < 9) ? 2'd0 : 2'd3;
    r.wd = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
    if ($urandom_range(0, 7) == 0) begin
      r.x = 4'($urandom_range(0, 15));
      r.y = 4'($urandom_range(0, 15));
    end else begin
      r.x = 4'($urandom_range(0, 3));
      r.y = 4'($urandom_range(0, 3));
    end
    return r;
  endfunction

  task automatic model_reset();
    busy_left = 256; infl = 0; resp_due = -1;
    last_id = 1'b1; placed = 1'b0;
    l_id = 1'b0; l_hit = 1'b0; l_data = 2'd0;
    exp_disp = 2'd0;
    for (int i = 0; i < 256; i++) begin board[i] = 2'd0; shown[i] = 2'd0; end
  endtask

  task automatic drive(input int c);
    if (c < 3) rst = 1'b1;
    else if (rst_left > 0) begin rst = 1'b1; rst_left--; end
    else if (!abort_done && c >= 1500 && infl == 2) begin
      rst = 1'b1; rst_left = 1; abort_done = 1'b1;
    end else rst = 1'b0;
    clear = (c == 700) || (c >= RND_START && $urandom_range(0, 299) == 0);
    for (int i = 0; i < 2; i++) begin
      if (!rv[i]) begin
        if (i == 0 && dq0.size() > 0) begin cur[i] = dq0.pop_front(); rv[i] = 1'b1; end
        else if (i == 1 && dq1.size() > 0) begin cur[i] = dq1.pop_front(); rv[i] = 1'b1; end
        else if (c >= RND_START && $urandom_range(0, 1) == 1) begin
          cur[i] = rand_req(); rv[i] = 1'b1;
        end
      end
    end
    req0_valid = rv[0]; req0_op = cur[0].op; req0_x = cur[0].x; req0_y = cur[0].y; req0_wdata = cur[0].wd;
    req1_valid = rv[1]; req1_op = cur[1].op; req1_x = cur[1].x; req1_y = cur[1].y; req1_wdata = cur[1].wd;
    if (c < RND_START) begin disp_x = 4'd3; disp_y = 4'd5; end
    else begin disp_x = 4'($urandom_range(0, 15)); disp_y = 4'($urandom_range(0, 15)); end
  endtask

  task automatic step_model();
    bit   e_busy, idle, r0, r1, who;
    int   ships;
    req_t q;
    logic [7:0] a;
    logic [1:0] old, nv;
    bit   h;
    if (rst) begin
      model_reset();
      return;
    end
    e_busy = (busy_left > 0);
    idle   = !e_busy && (infl == 0);
    r0 = idle && !clear && rv[0] && (!rv[1] || last_id);
    r1 = idle && !clear && rv[1] && (!rv[0] || !last_id);
    check("busy", busy, e_busy);
    check("req0_ready", req0_ready, r0);
    check("req1_ready", req1_ready, r1);
    if (e_busy) begin
      check("ships_left_clear", ships_left, 0);
      check("all_sunk_clear", all_sunk, 0);
    end
    check("disp_cell", disp_cell, exp_disp);
    if (resp_due == cyc) begin
      ships = count_ships();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_id", rsp_id, e_id);
      check("rsp_data", rsp_data, e_data);
      check("rsp_hit", rsp_hit, e_hit);
      check("ships_left", ships_left, ships);
      check("all_sunk", all_sunk, (placed && ships == 0) ? 1 : 0);
      $display("rsp id=%0d op=%0d x=%0d y=%0d old=%0d hit=%0d ships=%0d",
               e_id, e_op, e_addr[3:0], e_addr[7:4], e_data, e_hit, ships);
      l_id = e_id; l_data = e_data; l_hit = e_hit;
      shown[e_addr] = e_new;
      resp_due = -1;
    end else begin
      check("rsp_valid_idle", rsp_valid, 0);
      check("rsp_id_hold", rsp_id, l_id);
      check("rsp_data_hold", rsp_data, l_data);
      check("rsp_hit_hold", rsp_hit, l_hit);
    end
    exp_disp = e_busy ? 2'd0 : shown[{disp_y, disp_x}];
    if (e_busy) busy_left--;
    if (infl > 0) infl--;
    if (r0 || r1) begin
      who = r1;
      q = cur[who];
      a = {q.y, q.x};
      old = board[a]; nv = old; h = 1'b0;
      if (q.op == 2'd1) nv = q.wd;
      else if (q.op == 2'd2) begin
        if (old == 2'd1) begin nv = 2'd3; h = 1'b1; end
        else if (old == 2'd0) nv = 2'd2;
      end
      if (q.op == 2'd1 && q.wd == 2'd1) placed = 1'b1;
      board[a] = nv;
      e_id = who; e_data = old; e_hit = h; e_new = nv; e_addr = a; e_op = q.op;
      last_id = who; rv[who] = 1'b0;
      infl = 2; resp_due = cyc + 3;
    end else if (idle && clear) begin
      busy_left = 256; placed = 1'b0;
      for (int i = 0; i < 256; i++) begin board[i] = 2'd0; shown[i] = 2'd0; end
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    req0_valid = 1'b0; req0_op = 2'd0; req0_x = 4'd0; req0_y = 4'd0; req0_wdata = 2'd0;
    req1_valid = 1'b0; req1_op = 2'd0; req1_x = 4'd0; req1_y = 4'd0; req1_wdata = 2'd0;
    disp_x = 4'd0; disp_y = 4'd0;
    rv[0] = 1'b0; rv[1] = 1'b0; cur[0] = '0; cur[1] = '0;
    rst_left = 0; abort_done = 1'b0; cyc = 0;
    model_reset();
    // Directed opening: place a ship, sink it, shoot it again, miss on (0,0),
    // read back the miss; port 1 contends with reads from the start.
    dq0.push_back('{op: 2'd1, x: 4'd3, y: 4'd5, wd: 2'd1});
    dq0.push_back('{op: 2'd2, x: 4'd3, y: 4'd5, wd: 2'd0});
    dq0.push_back('{op: 2'd2, x: 4'd3, y: 4'd5, wd: 2'd0});
    dq0.push_back('{op: 2'd2, x: 4'd0, y: 4'd0, wd: 2'd0});
    dq0.push_back('{op: 2'd0, x: 4'd0, y: 4'd0, wd: 2'd0});
    dq1.push_back('{op: 2'd0, x: 4'd3, y: 4'd5, wd: 2'd0});
    dq1.push_back('{op: 2'd3, x: 4'd3, y: 4'd5, wd: 2'd0});
    dq1.push_back('{op: 2'd0, x: 4'd0, y: 4'd0, wd: 2'd0});
    for (int c = 0; c < N_CYCLES; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      @(negedge clk);
      step_model();
      cyc++;
    end
    if (!abort_done) check("abort_reset_reached", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
